// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : Fetch-unit bus bundle (instruction memory, IR and redirect).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if #(
   parameter int IW = 16
);
   logic          imem_req;
   logic [7:0]    imem_addr;
   logic          imem_ready;
   logic [IW-1:0] imem_rdata;
   logic          ir_valid;
   logic          ir_ready;
   logic [IW-1:0] ir_instr;
   logic [7:0]    ir_pc;
   logic [1:0]    opcode;
   logic          br_taken;
   logic [7:0]    br_target;

   modport master (
      output imem_req, imem_addr, ir_valid, ir_instr, ir_pc, opcode,
      input  imem_ready, imem_rdata, ir_ready, br_taken, br_target
   );

   modport slave (
      input  imem_req, imem_addr, ir_valid, ir_instr, ir_pc, opcode,
      output imem_ready, imem_rdata, ir_ready, br_taken, br_target
   );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Single-outstanding instruction fetch with IR handshake and
//            branch redirect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter int         IW       = 16
) (
   input  wire                  clk,
   input  wire                  rst_n,
   instr_fetch_unit_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t        r_state;
   logic [7:0]    r_pc;
   logic          r_imemReq;
   logic          r_irValid;
   logic [IW-1:0] r_irInstr;
   logic [7:0]    r_irPc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_pc      <= RESET_PC;
         r_imemReq <= 1'b0;
         r_irValid <= 1'b0;
         r_irInstr <= '0;
         r_irPc    <= 8'h00;
      end else if (bus.br_taken) begin
         // Redirect wins everywhere: any same-cycle response is dropped and
         // a HOLD-cycle ir_ready is still honoured by clearing the IR valid.
         r_pc      <= bus.br_target;
         r_irValid <= 1'b0;
         r_state   <= REQ;
         r_imemReq <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_state   <= REQ;
               r_imemReq <= 1'b1;
            end
            REQ: begin
               if (bus.imem_ready) begin
                  r_irInstr <= bus.imem_rdata;
                  r_irPc    <= r_pc;
                  r_irValid <= 1'b1;
                  r_pc      <= r_pc + 8'd1;
                  r_state   <= HOLD;
                  r_imemReq <= 1'b0;
               end
            end
            HOLD: begin
               if (bus.ir_ready) begin
                  r_irValid <= 1'b0;
                  r_state   <= REQ;
                  r_imemReq <= 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_imemReq <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req  = r_imemReq;
   assign bus.imem_addr = r_pc;
   assign bus.ir_valid  = r_irValid;
   assign bus.ir_instr  = r_irInstr;
   assign bus.ir_pc     = r_irPc;
   assign bus.opcode    = r_irInstr[IW-1:IW-2];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed self-checking bench for instr_fetch_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

   logic clk;
   logic rst_n;
   int   nVec;
   int   nErr;

   instr_fetch_unit_if #(.IW(16)) bus ();

   instr_fetch_unit #(.RESET_PC(8'h00), .IW(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      nVec++; if (bus.imem_req !== 1'b0) begin nErr++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
      nVec++; if (bus.imem_addr !== 8'h00) begin nErr++; $display("FAIL rst_addr: got %h want 00", bus.imem_addr); end
      nVec++; if (bus.ir_valid !== 1'b0) begin nErr++; $display("FAIL rst_valid: got %b want 0", bus.ir_valid); end
      nVec++; if (bus.ir_instr !== 16'h0000) begin nErr++; $display("FAIL rst_instr: got %h want 0000", bus.ir_instr); end
      nVec++; if (bus.ir_pc !== 8'h00) begin nErr++; $display("FAIL rst_irpc: got %h want 00", bus.ir_pc); end
      nVec++; if (bus.opcode !== 2'b00) begin nErr++; $display("FAIL rst_opcode: got %b want 00", bus.opcode); end
      tick(); tick();
      rst_n = 1'b1;
      nVec++; if (bus.imem_req !== 1'b0) begin nErr++; $display("FAIL rel_req: got %b want 0", bus.imem_req); end
      tick();
      nVec++; if (bus.imem_req !== 1'b1) begin nErr++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
      nVec++; if (bus.imem_addr !== 8'h00) begin nErr++; $display("FAIL first_addr: got %h want 00", bus.imem_addr); end
   endtask

   task automatic test_zero_wait();
      bus.imem_ready = 1'b1;
      bus.ir_ready   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.imem_rdata = 16'h1000 | 16'(i);
         nVec++; if (bus.imem_req !== 1'b1) begin nErr++; $display("FAIL zw_req[%0d]: got %b want 1", i, bus.imem_req); end
         nVec++; if (bus.imem_addr !== 8'(i)) begin nErr++; $display("FAIL zw_addr[%0d]: got %h want %h", i, bus.imem_addr, 8'(i)); end
         nVec++; if (bus.ir_valid !== 1'b0) begin nErr++; $display("FAIL zw_idle_valid[%0d]: got %b want 0", i, bus.ir_valid); end
         tick();
         nVec++; if (bus.ir_valid !== 1'b1) begin nErr++; $display("FAIL zw_valid[%0d]: got %b want 1", i, bus.ir_valid); end
         nVec++; if (bus.ir_pc !== 8'(i)) begin nErr++; $display("FAIL zw_irpc[%0d]: got %h want %h", i, bus.ir_pc, 8'(i)); end
         nVec++; if (bus.ir_instr !== (16'h1000 | 16'(i))) begin nErr++; $display("FAIL zw_instr[%0d]: got %h want %h", i, bus.ir_instr, 16'h1000 | 16'(i)); end
         nVec++; if (bus.imem_req !== 1'b0) begin nErr++; $display("FAIL zw_hold_req[%0d]: got %b want 0", i, bus.imem_req); end
         tick();
      end
   endtask

   task automatic test_wait_states();
      bus.imem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         nVec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h03) begin nErr++; $display("FAIL ws_hold[%0d]: got req %b addr %h want 1 03", k, bus.imem_req, bus.imem_addr); end
         nVec++; if (bus.ir_valid !== 1'b0) begin nErr++; $display("FAIL ws_valid[%0d]: got %b want 0", k, bus.ir_valid); end
         tick();
      end
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 16'h5A5A;
      nVec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h03) begin nErr++; $display("FAIL ws_last: got req %b addr %h want 1 03", bus.imem_req, bus.imem_addr); end
      tick();
      nVec++; if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 16'h5A5A || bus.ir_pc !== 8'h03) begin nErr++; $display("FAIL ws_load: got v%b %h pc %h want v1 5a5a pc 03", bus.ir_valid, bus.ir_instr, bus.ir_pc); end
      bus.imem_ready = 1'b0;
      tick();
      nVec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h04) begin nErr++; $display("FAIL ws_next: got req %b addr %h want 1 04", bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_hold_stall();
      bus.ir_ready   = 1'b0;
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 16'hC123;
      tick();
      bus.imem_rdata = 16'hFFFF;
      for (int k = 0; k < 5; k++) begin
         nVec++; if (bus.ir_valid !== 1'b1) begin nErr++; $display("FAIL hs_valid[%0d]: got %b want 1", k, bus.ir_valid); end
         nVec++; if (bus.ir_instr !== 16'hC123 || bus.ir_pc !== 8'h04) begin nErr++; $display("FAIL hs_ir[%0d]: got %h pc %h want c123 pc 04", k, bus.ir_instr, bus.ir_pc); end
         nVec++; if (bus.opcode !== 2'b11) begin nErr++; $display("FAIL hs_opcode[%0d]: got %b want 11", k, bus.opcode); end
         nVec++; if (bus.imem_req !== 1'b0) begin nErr++; $display("FAIL hs_req[%0d]: got %b want 0", k, bus.imem_req); end
         tick();
      end
      bus.ir_ready   = 1'b1;
      bus.imem_ready = 1'b0;
      tick();
      nVec++; if (bus.ir_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h05) begin nErr++; $display("FAIL hs_release: got v%b req %b addr %h want v0 req1 05", bus.ir_valid, bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_branch();
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 16'h7777;
      bus.br_taken   = 1'b1;
      bus.br_target  = 8'h40;
      tick();
      bus.br_taken   = 1'b0;
      nVec++; if (bus.ir_valid !== 1'b0) begin nErr++; $display("FAIL br_valid: got %b want 0", bus.ir_valid); end
      nVec++; if (bus.ir_instr !== 16'hC123 || bus.ir_pc !== 8'h04) begin nErr++; $display("FAIL br_ir: got %h pc %h want c123 pc 04", bus.ir_instr, bus.ir_pc); end
      nVec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h40) begin nErr++; $display("FAIL br_addr: got req %b addr %h want 1 40", bus.imem_req, bus.imem_addr); end
      bus.imem_rdata = 16'h8001;
      bus.ir_ready   = 1'b0;
      tick();
      nVec++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 8'h40 || bus.opcode !== 2'b10) begin nErr++; $display("FAIL br_fetch: got v%b pc %h op %b want v1 40 10", bus.ir_valid, bus.ir_pc, bus.opcode); end
      // Redirect coinciding with decode acceptance in HOLD
      bus.ir_ready   = 1'b1;
      bus.br_taken   = 1'b1;
      bus.br_target  = 8'hFE;
      bus.imem_ready = 1'b0;
      tick();
      bus.br_taken   = 1'b0;
      nVec++; if (bus.ir_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'hFE) begin nErr++; $display("FAIL br_hold: got v%b req %b addr %h want v0 req1 fe", bus.ir_valid, bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_pc_wrap();
      bus.imem_ready = 1'b1;
      bus.ir_ready   = 1'b1;
      bus.imem_rdata = 16'h2222;
      tick();
      nVec++; if (bus.ir_pc !== 8'hFE) begin nErr++; $display("FAIL wrap_irpc0: got %h want fe", bus.ir_pc); end
      tick();
      nVec++; if (bus.imem_addr !== 8'hFF) begin nErr++; $display("FAIL wrap_addr0: got %h want ff", bus.imem_addr); end
      tick();
      nVec++; if (bus.ir_pc !== 8'hFF || bus.ir_valid !== 1'b1) begin nErr++; $display("FAIL wrap_irpc1: got %h v%b want ff v1", bus.ir_pc, bus.ir_valid); end
      tick();
      nVec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin nErr++; $display("FAIL wrap_addr1: got req %b addr %h want 1 00", bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_reset_mid_fetch();
      bus.imem_ready = 1'b0;
      bus.br_taken   = 1'b1;
      bus.br_target  = 8'h33;
      tick();
      bus.br_taken   = 1'b0;
      tick();
      nVec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h33) begin nErr++; $display("FAIL mr_pre: got req %b addr %h want 1 33", bus.imem_req, bus.imem_addr); end
      #2 rst_n = 1'b0;
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 16'h9999;
      #1;
      nVec++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h00) begin nErr++; $display("FAIL mr_async: got req %b addr %h want 0 00", bus.imem_req, bus.imem_addr); end
      nVec++; if (bus.ir_instr !== 16'h0000 || bus.ir_pc !== 8'h00 || bus.ir_valid !== 1'b0) begin nErr++; $display("FAIL mr_ir: got %h pc %h v%b want 0000 00 v0", bus.ir_instr, bus.ir_pc, bus.ir_valid); end
      tick(); tick();
      nVec++; if (bus.ir_valid !== 1'b0 || bus.imem_req !== 1'b0) begin nErr++; $display("FAIL mr_late_ready: got v%b req %b want v0 req0", bus.ir_valid, bus.imem_req); end
      rst_n = 1'b1;
      bus.imem_rdata = 16'h4321;
      tick();
      nVec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00 || bus.ir_valid !== 1'b0) begin nErr++; $display("FAIL mr_first: got req %b addr %h v%b want 1 00 v0", bus.imem_req, bus.imem_addr, bus.ir_valid); end
      tick();
      nVec++; if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 16'h4321 || bus.ir_pc !== 8'h00 || bus.opcode !== 2'b01) begin nErr++; $display("FAIL mr_fetch: got v%b %h pc %h op %b want v1 4321 00 01", bus.ir_valid, bus.ir_instr, bus.ir_pc, bus.opcode); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      nVec           = 0;
      nErr           = 0;
      rst_n          = 1'b1;
      bus.imem_ready = 1'b0;
      bus.imem_rdata = 16'h0000;
      bus.ir_ready   = 1'b0;
      bus.br_taken   = 1'b0;
      bus.br_target  = 8'h00;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_hold_stall();
      test_branch();
      test_pc_wrap();
      test_reset_mid_fetch();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 8'h00, PC value loaded on reset.
REQ-002 Parameter: IW, default 16, instruction width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: imem_req  output  1  instruction-memory read request.
REQ-006 Port: imem_addr  output  8  word address of the request, equal to the current PC.
REQ-007 Port: imem_ready  input  1  memory response strobe; imem_rdata is valid in the same cycle.
REQ-008 Port: imem_rdata  input  IW  instruction word returned by memory.
REQ-009 Port: ir_valid  output  1  the instruction register holds an instruction for decode.
REQ-010 Port: ir_ready  input  1  decode accepts the IR contents this cycle.
REQ-011 Port: ir_instr  output  IW  instruction register contents.
REQ-012 Port: ir_pc  output  8  PC of the instruction held in the IR.
REQ-013 Port: opcode  output  2  ir_instr[IW-1:IW-2]; drives the main control decoder.
REQ-014 Port: br_taken  input  1  branch redirect strobe from execute (Branch asserted and condition met).
REQ-015 Port: br_target  input  8  redirect address, sampled when br_taken=1.

Function
REQ-016 The FSM SHALL have three states: IDLE, REQ and HOLD, and SHALL leave IDLE for REQ unconditionally on the first clock edge after reset release.
REQ-017 In REQ:
- imem_req SHALL be 1 and imem_addr SHALL equal pc.
- When imem_ready=1, the edge SHALL load ir_instr<=imem_rdata, ir_pc<=pc and ir_valid<=1, advance pc<=pc+1, and move the FSM to HOLD.
- When imem_ready=0, the request SHALL be held and the address SHALL stay stable.
REQ-018 In IDLE and HOLD, imem_req SHALL be 0.
REQ-019 In HOLD:
- ir_valid SHALL stay 1 and the IR contents SHALL stay stable while ir_ready=0.
- When ir_ready=1, the edge SHALL clear ir_valid and move the FSM to REQ.
REQ-020 Fetch-to-IR latency SHALL be exactly one edge after the imem_ready cycle; back-to-back throughput SHALL be one instruction per 2 cycles with zero-wait memory and ir_ready held high.
REQ-021 PC arithmetic SHALL be 8-bit modulo; 8'hFF+1 SHALL wrap to 8'h00 with no flag.
REQ-022 br_taken=1 SHALL take priority over all other events in every state. On that edge:
- pc<=br_target and ir_valid<=0.
- The FSM SHALL move to REQ.
- A same-cycle imem_ready response SHALL be discarded, leaving the IR unchanged and pc not incremented.
REQ-023 If br_taken=1 and ir_ready=1 occur in the same HOLD cycle, the handshake SHALL still complete, i.e. the instruction counts as consumed, and the redirect SHALL be applied.
REQ-024 opcode SHALL be purely combinational from ir_instr and SHALL be meaningful only when ir_valid=1.
REQ-025 No memory request SHALL be issued while ir_valid=1, so at most one instruction is in flight.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, pc=RESET_PC, imem_req=0 and imem_addr=RESET_PC.
- ir_valid=0, ir_instr=0, ir_pc=0 and opcode=2'b00.
REQ-027 A reset asserted mid-fetch or mid-hold SHALL abandon the transaction; a late imem_ready during reset SHALL be ignored.
REQ-028 After rst_n deasserts, the first imem_req SHALL appear in the cycle following the first rising edge.

Verification
REQ-029 Reset then zero-wait memory with ir_ready=1 -> imem_addr sequence 0x00, 0x01, 0x02, with ir_valid pulses 2 cycles apart and ir_pc matching each address.
REQ-030 Memory with imem_ready delayed 3 cycles -> imem_req held 4 cycles with imem_addr stable; IR loaded one edge after imem_ready.
REQ-031 Load ir_instr=16'hC123 and hold ir_ready=0 for 5 cycles -> ir_valid=1, ir_instr stable, opcode=2'b11, imem_req=0 throughout.
REQ-032 br_taken=1 with br_target=0x40 in the same cycle as imem_ready -> response discarded, IR unchanged, next imem_addr=0x40.
REQ-033 PC at 0xFF -> after the fetch completes, the next imem_addr=0x00.
REQ-034 rst_n asserted low while in REQ with imem_ready pending -> outputs reach reset values asynchronously; the first post-reset request goes to RESET_PC.
